univ_shift_reg: RTL and testbench
=================================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNTW, default 4: width of the burst count input.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port mode  input  3: operation select (see REQ-012).
REQ-006 SHALL have port en  input  1: single-step request; applies mode once per cycle when idle.
REQ-007 SHALL have port sin  input  1: serial input bit for shl/shr.
REQ-008 SHALL have port pdata  input  WIDTH: parallel load data.
REQ-009 SHALL have port start  input  1: burst request; executes the mode count times.
REQ-010 SHALL have port count  input  CNTW: burst length, unsigned.
REQ-011 SHALL have outputs q (WIDTH, register contents), sout (1, last departing bit), busy (1, burst running), done (1, burst-complete pulse).

Function
REQ-012 mode encoding SHALL be: 000 hold; 001 shl (q<={q[W-2:0],sin}); 010 shr (q<={sin,q[W-1:1]}); 011 rotl; 100 rotr; 101 ashr (MSB replicated); 110 load pdata; 111 clear to 0.
REQ-013 sout SHALL update on every applied shift/rotate to the departing bit (old q[W-1] for shl/rotl, old q[0] for shr/rotr/ashr) and SHALL hold its value for hold/load/clear.
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE, start=1, count!=0: latch mode and count, go to RUN, q unchanged on that edge.
REQ-016 IDLE, start=1, count=0: go directly to DONE; q and sout unchanged.
REQ-017 IDLE, start=0, en=1: apply current mode once on that edge; remain IDLE.
REQ-018 start SHALL take priority over en when both are 1 in IDLE.
REQ-019 RUN: apply latched mode once per edge, decrementing remaining count; on the edge applying the final op go to DONE.
REQ-020 RUN: mode, count, start and en changes SHALL be ignored; sin and pdata SHALL be sampled live each cycle.
REQ-021 DONE: no op applied; lasts exactly one cycle, then IDLE; start/en in DONE ignored.
REQ-022 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-023 Latency: start sampled at edge k with count=N>0 -> ops at edges k+1..k+N, done high for the cycle following edge k+N.
REQ-024 Count decrement SHALL be CNTW-bit unsigned; count=2^CNTW-1 SHALL run that many ops with no wrap.

Reset
REQ-025 reset=1 SHALL immediately, without a clock edge, force q=0, sout=0, busy=0, done=0, state IDLE, latched mode/count=0.
REQ-026 reset asserted mid-burst SHALL abort the burst; no done pulse is generated for it.
REQ-027 After reset deasserts, the first rising edge SHALL evaluate inputs normally from IDLE.

Verification (WIDTH=8, CNTW=4)
REQ-028 en=1 mode=110 pdata=0xA5, then en=1 mode=011 -> q=0xA5, then q=0x4B, sout=1.
REQ-029 From q=0, en=1 mode=001 with sin=1,0,1,1 on four edges -> q=0x0B, sout=0.
REQ-030 q=0x81, start=1 count=3 mode=101 -> busy high 3 cycles, q=0xC0,0xE0,0xF0, sout=1,0,0, done pulse one cycle, then IDLE.
REQ-031 start=1 count=0 -> done high next cycle, busy never high, q unchanged.
REQ-032 During a count=5 shl burst, toggle mode to 110 and pulse start/en -> ignored; exactly 5 shl ops, one done pulse.
REQ-033 Assert reset between clock edges mid-burst -> q=0, busy=0 immediately; no done pulse follows.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step and counted-burst operation.
// Bursts run through an IDLE -> RUN -> DONE sequence with busy/done status.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             en,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdata,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_ROTL = 3'd3;
    localparam logic [2:0] M_ROTR = 3'd4;
    localparam logic [2:0] M_ASHR = 3'd5;
    localparam logic [2:0] M_LOAD = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic             op_apply;
    logic [2:0]       op_mode;

    // Sequencing: decides whether an op is applied this edge and which one.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        op_apply = 1'b0;
        op_mode  = mode;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        mode_d  = mode;
                        cnt_d   = count;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (en) begin
                    op_apply = 1'b1;
                end
            end
            S_RUN: begin
                op_mode  = mode_q;
                op_apply = 1'b1;
                cnt_d    = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Datapath: next register contents and departing bit for the selected op.
    always_comb begin
        q_d    = q_q;
        sout_d = sout_q;
        if (op_apply) begin
            case (op_mode)
                M_SHL: begin
                    q_d    = {q_q[WIDTH-2:0], sin};
                    sout_d = q_q[WIDTH-1];
                end
                M_SHR: begin
                    q_d    = {sin, q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                M_ROTL: begin
                    q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    sout_d = q_q[WIDTH-1];
                end
                M_ROTR: begin
                    q_d    = {q_q[0], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                M_ASHR: begin
                    q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                    sout_d = q_q[0];
                end
                M_LOAD: begin
                    q_d = pdata;
                end
                M_CLR: begin
                    q_d = '0;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, CNTW=4): queue-based
// reference model compared every cycle, plus directed literal checks.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] mode = 3'd0;
    logic       en = 1'b0;
    logic       sin = 1'b0;
    logic [7:0] pdata = 8'd0;
    logic       start = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] q;
    logic       sout;
    logic       busy;
    logic       done;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    // reference model state
    int mq    = 0;
    int msout = 0;
    int mdone = 0;
    int pend[$];

    univ_shift_reg #(.WIDTH(8), .CNTW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .en    (en),
        .sin   (sin),
        .pdata (pdata),
        .start (start),
        .count (count),
        .q     (q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_apply(input int m, input int si, input int pd);
        case (m)
            1: begin msout = mq / 128; mq = (mq * 2) % 256 + si; end
            2: begin msout = mq % 2;   mq = mq / 2 + si * 128; end
            3: begin msout = mq / 128; mq = (mq * 2) % 256 + mq / 128; end
            4: begin msout = mq % 2;   mq = mq / 2 + (mq % 2) * 128; end
            5: begin msout = mq % 2;   mq = mq / 2 + (mq / 128) * 128; end
            6: mq = pd;
            7: mq = 0;
            default: ;
        endcase
    endfunction

    // Burst = a queue of pending ops; done follows the edge that empties it.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq = 0; msout = 0; mdone = 0;
            pend.delete();
        end else if (mdone != 0) begin
            mdone = 0;
        end else if (pend.size() > 0) begin
            model_apply(pend.pop_front(), int'(sin), int'(pdata));
            if (pend.size() == 0) mdone = 1;
        end else if (start) begin
            if (count == 4'd0) mdone = 1;
            else for (int i = 0; i < int'(count); i++) pend.push_back(int'(mode));
        end else if (en) begin
            model_apply(int'(mode), int'(sin), int'(pdata));
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            chk("cmp_q",    int'(q),    mq);
            chk("cmp_sout", int'(sout), msout);
            chk("cmp_busy", int'(busy), (pend.size() > 0) ? 1 : 0);
            chk("cmp_done", int'(done), mdone);
        end
    end

    task automatic cyc(input logic [2:0] m, input logic e, input logic s,
                       input logic [3:0] c, input logic si, input logic [7:0] pd);
        mode = m; en = e; start = s; count = c; sin = si; pdata = pd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(3'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    endtask

    initial begin
        int nb;
        logic [3:0] sv;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", int'(q), 0);
        chk("rst_sout", int'(sout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        run_chk = 1'b1;
        #2 reset = 1'b0;

        // load then rotate left
        cyc(3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 8'hA5);
        chk("load_a5", int'(q), 8'hA5);
        cyc(3'd3, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
        chk("rotl_q", int'(q), 8'h4B);
        chk("rotl_sout", int'(sout), 1);

        // clear then shift in 1,0,1,1
        cyc(3'd7, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
        chk("clear_q", int'(q), 0);
        sv = 4'b1101;
        for (int i = 0; i < 4; i++) cyc(3'd1, 1'b1, 1'b0, 4'd0, sv[i], 8'h00);
        chk("shl_q", int'(q), 8'h0B);
        chk("shl_sout", int'(sout), 0);

        // ashr burst of 3 from 0x81
        cyc(3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 8'h81);
        cyc(3'd5, 1'b0, 1'b1, 4'd3, 1'b0, 8'h00);
        chk("b3_start_q", int'(q), 8'h81);
        chk("b3_start_busy", int'(busy), 1);
        idle();
        chk("b3_q1", int'(q), 8'hC0); chk("b3_s1", int'(sout), 1); chk("b3_busy1", int'(busy), 1);
        idle();
        chk("b3_q2", int'(q), 8'hE0); chk("b3_s2", int'(sout), 0); chk("b3_busy2", int'(busy), 1);
        idle();
        chk("b3_q3", int'(q), 8'hF0); chk("b3_s3", int'(sout), 0);
        chk("b3_busy3", int'(busy), 0); chk("b3_done", int'(done), 1);
        idle();
        chk("b3_done_end", int'(done), 0);

        // zero-length burst
        cyc(3'd1, 1'b0, 1'b1, 4'd0, 1'b1, 8'h00);
        chk("b0_done", int'(done), 1); chk("b0_busy", int'(busy), 0); chk("b0_q", int'(q), 8'hF0);
        idle();
        chk("b0_done_end", int'(done), 0); chk("b0_q_end", int'(q), 8'hF0);

        // shl burst of 5 with distracting mode/start/en changes
        cyc(3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 8'h01);
        cyc(3'd1, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00);
        nb = int'(busy);
        sv = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            cyc(3'd6, 1'b1, 1'b1, 4'd9, (i < 4) ? sv[i] : 1'b1, 8'hFF);
            nb += int'(busy);
        end
        chk("b5_q", int'(q), 8'h33);
        chk("b5_busy_cycles", nb, 5);
        chk("b5_done", int'(done), 1);
        idle();
        chk("b5_done_end", int'(done), 0); chk("b5_q_end", int'(q), 8'h33);

        // maximum count: 15 rotl == one rotr
        cyc(3'd3, 1'b0, 1'b1, 4'd15, 1'b0, 8'h00);
        nb = int'(busy);
        for (int i = 0; i < 15; i++) begin
            idle();
            nb += int'(busy);
        end
        chk("b15_busy_cycles", nb, 15);
        chk("b15_done", int'(done), 1);
        chk("b15_q", int'(q), 8'h99);
        idle();

        // reset mid-burst between edges
        cyc(3'd1, 1'b0, 1'b1, 4'd5, 1'b1, 8'h00);
        idle();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("arst_q", int'(q), 0); chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0); chk("arst_sout", int'(sout), 0);
        #3 reset = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            nb += int'(done);
        end
        chk("arst_no_done", nb, 0);

        // normal single steps after reset
        cyc(3'd6, 1'b1, 1'b0, 4'd0, 1'b0, 8'h5A);
        chk("post_load", int'(q), 8'h5A);
        cyc(3'd2, 1'b1, 1'b0, 4'd0, 1'b1, 8'h00);
        chk("shr_q", int'(q), 8'hAD); chk("shr_sout", int'(sout), 0);
        cyc(3'd4, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
        chk("rotr_q", int'(q), 8'hD6); chk("rotr_sout", int'(sout), 1);
        cyc(3'd5, 1'b1, 1'b0, 4'd0, 1'b0, 8'h00);
        chk("ashr_q", int'(q), 8'hEB); chk("ashr_sout", int'(sout), 0);
        cyc(3'd6, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
        chk("en0_hold", int'(q), 8'hEB);
        idle();

        run_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
